// File: rtl/norm_sched_if.sv
// Handshake and datapath bundle for norm_sched.
// The slave modport is the scheduler; the master modport is its environment,
// meaning the upstream producer, the downstream consumer and the normalize datapath.
interface norm_sched_if #(
  parameter int NUM_CLASSES    = 4,
  parameter int NN_WIDTH       = 16,
  parameter int NORM_OUT_WIDTH = 16
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NN_WIDTH*NUM_CLASSES-1:0]       in_vector;
  logic [NN_WIDTH*NUM_CLASSES-1:0]       norm_in_vector;
  logic [NORM_OUT_WIDTH*NUM_CLASSES-1:0] norm_out_vector;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NORM_OUT_WIDTH*NUM_CLASSES-1:0] out_vector;
  logic                                  out_zero_sum;
  logic [15:0]                           done_count;

  modport master (
    output in_valid, in_vector, norm_out_vector, out_ready,
    input  in_ready, norm_in_vector, out_valid, out_vector, out_zero_sum, done_count
  );

  modport slave (
    input  in_valid, in_vector, norm_out_vector, out_ready,
    output in_ready, norm_in_vector, out_valid, out_vector, out_zero_sum, done_count
  );
endinterface

// File: rtl/norm_sched.sv
// norm_sched: accepts one score vector and holds it stable on the normalize
// datapath for NORM_LAT cycles. It then captures the datapath result into a
// registered output with a valid/ready handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | in_ready=1; waiting for an input vector
//   HOLD    | operand held on norm_in_vector; wait counter running down
//   CAPTURE | datapath result valid; load out_vector once the output slot frees
module norm_sched #(
  parameter int NUM_CLASSES    = 4,
  parameter int NN_WIDTH       = 16,
  parameter int NORM_OUT_WIDTH = 16,
  parameter int NORM_LAT       = 3
) (
  input  logic        clock,
  input  logic        reset,
  norm_sched_if.slave bus
);

  localparam int IW = NN_WIDTH * NUM_CLASSES;
  localparam int OW = NORM_OUT_WIDTH * NUM_CLASSES;
  localparam int CW = (NORM_LAT > 1) ? $clog2(NORM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NORM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   norm_in_q, norm_in_d;
  logic            zero_q, zero_d;
  logic [OW-1:0]   out_vec_q, out_vec_d;
  logic            out_zero_q, out_zero_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     done_q, done_d;
  logic            deliver;
  logic            capture;

  // State, operand and output registers; synchronous reset discards any in-flight vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      norm_in_q   <= '0;
      zero_q      <= 1'b0;
      out_vec_q   <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      norm_in_q   <= norm_in_d;
      zero_q      <= zero_d;
      out_vec_q   <= out_vec_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic. A delivery retires the output slot first; a capture in the
  // same cycle then refills it, so out_valid stays high across back-to-back results.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    norm_in_d   = norm_in_q;
    zero_d      = zero_q;
    out_vec_d   = out_vec_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    deliver     = out_valid_q & bus.out_ready;
    capture     = 1'b0;

    if (deliver) begin
      done_d      = done_q + 16'd1;
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          norm_in_d = bus.in_vector;
          zero_d    = (bus.in_vector == '0);
          cnt_d     = CNT_LOAD;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CAPTURE: begin
        capture = ~out_valid_q | bus.out_ready;
        if (capture) begin
          // A zero-sum vector never trusts the datapath, which may divide by zero.
          out_vec_d   = zero_q ? '0 : bus.norm_out_vector;
          out_zero_d  = zero_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready       = (state_q == IDLE) & ~reset;
  assign bus.norm_in_vector = norm_in_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_vector     = out_vec_q;
  assign bus.out_zero_sum   = out_zero_q;
  assign bus.done_count     = done_q;

endmodule

// File: tb/tb_norm_sched.sv
// Bench for norm_sched (NUM_CLASSES=4, NORM_LAT=3).
// It contains a stand-in normalize datapath that drives garbage until its operand has been
// stable for NORM_LAT cycles, and a transaction-level model checked every cycle.
// Directed scenarios then pin that model with hand-computed literals.
module tb_norm_sched;
  localparam int NUM_CLASSES = 4;
  localparam int NN_WIDTH    = 16;
  localparam int NOW         = 16;
  localparam int NORM_LAT    = 3;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  norm_sched_if #(.NUM_CLASSES(NUM_CLASSES), .NN_WIDTH(NN_WIDTH), .NORM_OUT_WIDTH(NOW)) bus ();

  norm_sched #(
    .NUM_CLASSES(NUM_CLASSES), .NN_WIDTH(NN_WIDTH),
    .NORM_OUT_WIDTH(NOW), .NORM_LAT(NORM_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Datapath stand-in: element i -> 5*x + (i+1), truncated to 16 bits.
  function automatic logic [63:0] dp(input logic [63:0] v);
    logic [63:0] r;
    logic [15:0] x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = v[16*i +: 16];
      r[16*i +: 16] = x * 16'd5 + 16'(i + 1);
    end
    return r;
  endfunction

  logic [63:0] dp_prev = '0;
  int          dp_stable = 0;
  always @(negedge clock) begin
    if (bus.norm_in_vector != dp_prev) dp_stable = 0;
    else if (dp_stable < 1000) dp_stable++;
    dp_prev = bus.norm_in_vector;
    bus.norm_out_vector = (dp_stable >= NORM_LAT) ? dp(bus.norm_in_vector) : {4{16'hDEAD}};
  end

  // Transaction-level model. One item may be in flight. Its result becomes available
  // NORM_LAT+1 edges after acceptance, and it moves to the output slot when that slot
  // is empty or being drained.
  int          cyc = 0;
  bit          m_live = 0;
  bit          m_inflight = 0;
  int          m_due = 0;
  logic [63:0] m_item_vec = '0;
  bit          m_item_zero = 0;
  logic [63:0] m_norm_in = '0;
  bit          m_valid = 0;
  logic [63:0] m_vec = '0;
  bit          m_zero = 0;
  logic [15:0] m_done = '0;
  bit          m_rdy, m_dlv;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_live = 1; m_inflight = 0; m_valid = 0; m_vec = '0; m_zero = 0;
      m_done = '0; m_norm_in = '0;
    end else begin
      m_rdy = !m_inflight;
      m_dlv = m_valid && bus.out_ready;
      if (m_dlv) m_done = m_done + 16'd1;
      if (m_inflight && cyc >= m_due && (!m_valid || bus.out_ready)) begin
        m_valid = 1; m_vec = m_item_vec; m_zero = m_item_zero; m_inflight = 0;
      end else if (m_dlv) begin
        m_valid = 0;
      end
      if (m_rdy && bus.in_valid) begin
        m_inflight  = 1;
        m_item_zero = (bus.in_vector == '0);
        m_item_vec  = m_item_zero ? '0 : dp(bus.in_vector);
        m_norm_in   = bus.in_vector;
        m_due       = cyc + NORM_LAT + 1;
      end
    end
  end

  // Per-cycle comparison against the model, after the edge has settled.
  always @(posedge clock) begin
    #2;
    if (m_live) begin
      chk("cyc_in_ready",  64'(bus.in_ready), 64'(!m_inflight && !reset));
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("cyc_out_vector", bus.out_vector, m_vec);
      chk("cyc_out_zero",  64'(bus.out_zero_sum), 64'(m_zero));
      chk("cyc_norm_in",   bus.norm_in_vector, m_norm_in);
      chk("cyc_done",      64'(bus.done_count), 64'(m_done));
    end
  end

  // Offer v until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] v);
    bit ok;
    ok = 0;
    bus.in_vector = v;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      if (bus.in_ready) ok = 1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=no_accept expected=accept");
    end
  endtask

  localparam logic [63:0] VA = 64'h0004_0003_0002_0001;
  localparam logic [63:0] VB = 64'h0008_0007_0006_0005;
  localparam logic [63:0] VC = 64'h0001_0000_0000_0100;

  initial begin
    int last, nacc;
    logic [15:0] d0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done", 64'(bus.done_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic vector {1,2,3,4}
    send(VA);
    chk("t1_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("t1_norm_in", bus.norm_in_vector, VA);
    chk("t1_out_valid_e0", 64'(bus.out_valid), 64'd0);
    repeat (3) begin
      @(negedge clock);
      chk("t1_norm_in_held", bus.norm_in_vector, VA);
      chk("t1_out_valid_early", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clock);
    chk("t1_out_valid_e4", 64'(bus.out_valid), 64'd1);
    chk("t1_out_vector", bus.out_vector, 64'h0018_0012_000C_0006);
    chk("t1_zero", 64'(bus.out_zero_sum), 64'd0);
    @(negedge clock);
    chk("t1_done", 64'(bus.done_count), 64'd1);
    chk("t1_out_valid_cleared", 64'(bus.out_valid), 64'd0);

    // Zero-sum vector
    send(64'd0);
    repeat (3) @(negedge clock);
    chk("t2_out_valid_early", 64'(bus.out_valid), 64'd0);
    @(negedge clock);
    chk("t2_out_valid_e4", 64'(bus.out_valid), 64'd1);
    chk("t2_out_vector", bus.out_vector, 64'd0);
    chk("t2_zero", 64'(bus.out_zero_sum), 64'd1);
    @(negedge clock);
    chk("t2_done", 64'(bus.done_count), 64'd2);

    // Back-pressure: two vectors with out_ready low
    bus.out_ready = 1'b0;
    send(VB);
    send(VC);
    repeat (6) @(negedge clock);
    chk("t3_stall_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_stall_vector", bus.out_vector, 64'h002C_0026_0020_001A);
    chk("t3_stall_done", 64'(bus.done_count), 64'd2);
    chk("t3_stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("t3_swap_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_swap_vector", bus.out_vector, 64'h0009_0003_0002_0501);
    chk("t3_swap_done", 64'(bus.done_count), 64'd3);
    @(negedge clock);
    chk("t3_final_done", 64'(bus.done_count), 64'd4);
    chk("t3_final_valid", 64'(bus.out_valid), 64'd0);

    // in_valid held high: one accept every NORM_LAT+2 cycles
    bus.in_valid = 1'b1;
    last = -1;
    nacc = 0;
    for (int n = 0; n < 26; n++) begin
      bus.in_vector = {16'(n), 16'(n + 1), 16'(2 * n), 16'(n + 7)};
      if (bus.in_ready) begin
        if (last >= 0) chk("t4_accept_gap", 64'(n - last), 64'd5);
        last = n;
        nacc++;
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    chk("t4_accept_count", 64'(nacc), 64'd6);
    repeat (8) @(negedge clock);
    chk("t4_done", 64'(bus.done_count), 64'd10);

    // Reset one cycle after an accept
    send(VA);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_in_ready_rst", 64'(bus.in_ready), 64'd0);
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_out_vector", bus.out_vector, 64'd0);
    chk("t5_norm_in", bus.norm_in_vector, 64'd0);
    chk("t5_done", 64'(bus.done_count), 64'd0);
    chk("t5_zero", 64'(bus.out_zero_sum), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_in_ready_after", 64'(bus.in_ready), 64'd1);
    repeat (8) begin
      @(negedge clock);
      chk("t5_no_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // done_count wrap
    @(posedge clock);
    #3;
    force dut.done_q = 16'hFFFF;
    m_done = 16'hFFFF;
    #1;
    release dut.done_q;
    @(negedge clock);
    d0 = bus.done_count;
    chk("t6_preset", 64'(d0), 64'hFFFF);
    send(VB);
    repeat (6) @(negedge clock);
    chk("t6_wrap", 64'(bus.done_count), 64'h0000);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/norm_sched.md
NORM_SCHED -- requirements
Module: norm_sched

Interface
REQ-001 SHALL take parameter NUM_CLASSES, default 4: number of class scores per vector, a power of two, 2..64.
REQ-002 SHALL take parameter NN_WIDTH, default 16: bits per input class score.
REQ-003 SHALL take parameter NORM_OUT_WIDTH, default 16: bits per normalized output element.
REQ-004 SHALL take parameter NORM_LAT, default 3 (log2(NUM_CLASSES)+1): cycles the normalize datapath needs with its input held stable before its output is valid.
REQ-005 SHALL have the ports listed in REQ-006 to REQ-017, in that order.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream offers a score vector.
REQ-009 in_ready  output  1  block can accept a vector this cycle.
REQ-010 in_vector  input  NN_WIDTH*NUM_CLASSES  class scores; class i in bits [NN_WIDTH*i +: NN_WIDTH].
REQ-011 norm_in_vector  output  NN_WIDTH*NUM_CLASSES  registered operand driven to the normalize datapath.
REQ-012 norm_out_vector  input  NORM_OUT_WIDTH*NUM_CLASSES  result returned by the normalize datapath.
REQ-013 out_valid  output  1  out_vector holds a result.
REQ-014 out_ready  input  1  downstream takes the result.
REQ-015 out_vector  output  NORM_OUT_WIDTH*NUM_CLASSES  registered normalized vector.
REQ-016 out_zero_sum  output  1  qualifies out_vector; 1 when the source vector summed to zero.
REQ-017 done_count  output  16  number of results delivered (out_valid & out_ready), wraps 0xFFFF->0x0000.

Function
REQ-018 SHALL implement FSM states IDLE, HOLD, CAPTURE.
REQ-019 SHALL drive in_ready=1 only in IDLE.
REQ-020 In IDLE, in_valid=1 (accept edge E0) SHALL load in_vector into norm_in_vector, latch zero flag (all classes == 0), load wait counter with NORM_LAT-1, and go to HOLD.
REQ-021 In HOLD, norm_in_vector SHALL stay constant; counter decrements each cycle; at counter==0 the state SHALL go to CAPTURE.
REQ-022 In CAPTURE with out_valid==0 or out_ready==1, the block SHALL load out_vector (norm_out_vector, or all zeros if the zero flag is set), set out_zero_sum=zero flag and out_valid=1, and go to IDLE.
REQ-023 Unloaded latency SHALL be exactly NORM_LAT+1 cycles: out_valid rises at edge E0+NORM_LAT+1.
REQ-024 In CAPTURE with out_valid==1 and out_ready==0, the block SHALL stay in CAPTURE, keep norm_in_vector and out_vector unchanged, and capture on the first cycle out_ready==1.
REQ-025 In a cycle with out_valid & out_ready and no capture, the block SHALL clear out_valid on the next edge.
REQ-026 Simultaneous out_ready handshake and capture in one cycle SHALL replace out_vector with the new result, keep out_valid=1, and increment done_count once.
REQ-027 out_vector and out_zero_sum SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Unloaded throughput SHALL be one vector per NORM_LAT+2 cycles; no input vector is ever dropped or duplicated.
REQ-029 A zero-sum vector SHALL take the same latency as any other vector and SHALL NOT use the datapath result.
REQ-030 done_count SHALL increment by 1 on each cycle with out_valid & out_ready, wrapping modulo 2^16.

Reset
REQ-031 reset=1 at a rising edge SHALL force the state to IDLE, counter=0, norm_in_vector=0, out_vector=0, out_valid=0, out_zero_sum=0, and done_count=0.
REQ-032 Reset mid-operation (HOLD or CAPTURE) SHALL discard the in-flight vector; the first accept after reset is the cycle after reset deasserts.
REQ-033 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.

Verification
REQ-034 Bench SHALL cover: NUM_CLASSES=4, NORM_LAT=3, out_ready=1, vector {1,2,3,4} accepted at edge 0 -> norm_in_vector held for edges 1..3, out_valid=1 after edge 4, out_vector equals the datapath value, done_count=1.
REQ-035 Bench SHALL cover: vector {0,0,0,0} -> out_vector=0, out_zero_sum=1, out_valid after edge 4.
REQ-036 Bench SHALL cover: out_ready=0 with two vectors sent back-to-back -> the second stalls in CAPTURE, the first out_vector is stable, and after out_ready=1 both are delivered in order with done_count=2.
REQ-037 Bench SHALL cover: in_valid held high continuously with out_ready=1 -> an accept every 5 cycles and in_ready low in HOLD/CAPTURE.
REQ-038 Bench SHALL cover: reset asserted one cycle after accept -> out_valid never rises, all outputs 0, and in_ready=1 in the cycle after reset deasserts.
REQ-039 Bench SHALL cover: done_count preset by 65535 deliveries, then one more delivery -> done_count=0x0000.
